// File: rtl/seq_detector_1011_if.sv
// Serial-bit input, match pulse, match counter and debug state for the 1011 detector.
interface seq_detector_1011_if #(
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             cnt_clr;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic [2:0]       state_o;

    modport master (
        output din_valid, din, cnt_clr,
        input  detected, match_count, state_o
    );

    modport slave (
        input  din_valid, din, cnt_clr,
        output detected, match_count, state_o
    );
endinterface

// File: rtl/seq_detector_1011.sv
// Moore detector for serial pattern 1011 (first bit first), with a one-cycle
// match pulse and a saturating match counter.
module seq_detector_1011 #(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detector_1011_if.slave bus
);
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
        $error("seq_detector_1011: CNT_W must be in 2..16");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t           state, next_state;
    logic             det_q, det_next;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            det_q <= 1'b0;
            count <= '0;
        end else begin
            state <= next_state;
            det_q <= det_next;
            // Clear wins over a simultaneous match; the pulse itself is unaffected.
            if (bus.cnt_clr)
                count <= '0;
            else if (det_next && count != {CNT_W{1'b1}})
                count <= count + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (bus.din_valid) next_state = bus.din ? S1    : IDLE;
            S1:    if (bus.din_valid) next_state = bus.din ? S1    : S10;
            S10:   if (bus.din_valid) next_state = bus.din ? S101  : IDLE;
            S101:  if (bus.din_valid) next_state = bus.din ? S1011 : S10;
            S1011: if (bus.din_valid) next_state = bus.din ? S1    : (OVERLAP ? S10 : IDLE);
            // Codes 5..7 recover to IDLE regardless of din_valid.
            default: next_state = IDLE;
        endcase
        det_next = bus.din_valid && (next_state == S1011);
    end

    assign bus.detected    = det_q;
    assign bus.match_count = count;
    assign bus.state_o     = state;
endmodule
